// File: rtl/troco_dispenser.sv
// Change-return engine: pays a requested amount back as a greedy sequence of 25/10/5 coins,
// one coin per release handshake, while tracking per-denomination inventory.
module troco_dispenser #(
    parameter int unsigned AMT_W    = 7,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned INIT_N5  = 8,
    parameter int unsigned INIT_N10 = 8,
    parameter int unsigned INIT_N25 = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    output logic [1:0]       coin_out,
    output logic             coin_valid,
    input  logic             coin_ack,
    output logic             done,
    output logic             fail,
    output logic [AMT_W-1:0] remaining,
    input  logic             refill,
    output logic [CNT_W-1:0] n5,
    output logic [CNT_W-1:0] n10,
    output logic [CNT_W-1:0] n25
);

    localparam logic [1:0] CoinNone = 2'b00;
    localparam logic [1:0] Coin5    = 2'b01;
    localparam logic [1:0] Coin10   = 2'b10;
    localparam logic [1:0] Coin25   = 2'b11;

    localparam logic [AMT_W-1:0] Val5  = AMT_W'(5);
    localparam logic [AMT_W-1:0] Val10 = AMT_W'(10);
    localparam logic [AMT_W-1:0] Val25 = AMT_W'(25);

    localparam logic [CNT_W-1:0] Init5  = CNT_W'(INIT_N5);
    localparam logic [CNT_W-1:0] Init10 = CNT_W'(INIT_N10);
    localparam logic [CNT_W-1:0] Init25 = CNT_W'(INIT_N25);
    localparam logic [CNT_W-1:0] One    = CNT_W'(1);

    typedef enum logic [2:0] {StIdle, StSelect, StDispense, StDone, StFail} state_e;

    state_e           state_q;
    logic [AMT_W-1:0] remaining_q;
    logic [1:0]       coin_q;
    logic             coin_valid_q;
    logic             done_q;
    logic             fail_q;
    logic [CNT_W-1:0] n5_q;
    logic [CNT_W-1:0] n10_q;
    logic [CNT_W-1:0] n25_q;

    logic [1:0]       pick;
    logic [AMT_W-1:0] coin_val;
    logic             not_mult5;

    // Greedy denomination choice; only consulted once remaining is a nonzero multiple of 5,
    // so a 5-coin never exceeds the residue.
    always_comb begin
        pick = CoinNone;
        if (remaining_q >= Val25 && n25_q != '0) begin
            pick = Coin25;
        end else if (remaining_q >= Val10 && n10_q != '0) begin
            pick = Coin10;
        end else if (n5_q != '0) begin
            pick = Coin5;
        end
    end

    // Value of the coin currently presented to the release mechanism.
    always_comb begin
        coin_val = '0;
        case (coin_q)
            Coin5:   coin_val = Val5;
            Coin10:  coin_val = Val10;
            Coin25:  coin_val = Val25;
            default: coin_val = '0;
        endcase
    end

    assign not_mult5 = (remaining_q % Val5) != '0;

    // Main FSM with registered outputs and inventory counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            remaining_q  <= '0;
            coin_q       <= CoinNone;
            coin_valid_q <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            n5_q         <= Init5;
            n10_q        <= Init10;
            n25_q        <= Init25;
        end else begin
            case (state_q)
                StIdle: begin
                    // Refill and a new request may coincide; SELECT then sees the full counts.
                    if (refill) begin
                        n5_q  <= Init5;
                        n10_q <= Init10;
                        n25_q <= Init25;
                    end
                    if (req_valid) begin
                        remaining_q <= req_amount;
                        state_q     <= StSelect;
                    end
                end
                StSelect: begin
                    if (remaining_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else if (not_mult5 || pick == CoinNone) begin
                        fail_q  <= 1'b1;
                        state_q <= StFail;
                    end else begin
                        coin_q       <= pick;
                        coin_valid_q <= 1'b1;
                        state_q      <= StDispense;
                    end
                end
                StDispense: begin
                    if (coin_ack) begin
                        remaining_q <= remaining_q - coin_val;
                        case (coin_q)
                            Coin5:   n5_q  <= n5_q - One;
                            Coin10:  n10_q <= n10_q - One;
                            Coin25:  n25_q <= n25_q - One;
                            default: ;
                        endcase
                        coin_q       <= CoinNone;
                        coin_valid_q <= 1'b0;
                        state_q      <= StSelect;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                StFail: begin
                    fail_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign coin_out   = coin_q;
    assign coin_valid = coin_valid_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign remaining  = remaining_q;
    assign n5         = n5_q;
    assign n10        = n10_q;
    assign n25        = n25_q;

endmodule

// File: tb/tb_troco_dispenser.sv
// Self-checking bench for troco_dispenser: transaction-level greedy model plus per-cycle compare.
module tb_troco_dispenser;

    localparam int AMT_W = 7;
    localparam int CNT_W = 4;
    localparam int I5    = 8;
    localparam int I10   = 8;
    localparam int I25   = 4;

    localparam int PhIdle   = 0;
    localparam int PhSelect = 1;
    localparam int PhCoin   = 2;
    localparam int PhReport = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic [AMT_W-1:0] req_amount = '0;
    logic             req_ready;
    logic [1:0]       coin_out;
    logic             coin_valid;
    logic             coin_ack = 1'b0;
    logic             done;
    logic             fail;
    logic [AMT_W-1:0] remaining;
    logic             refill = 1'b0;
    logic [CNT_W-1:0] n5;
    logic [CNT_W-1:0] n10;
    logic [CNT_W-1:0] n25;

    troco_dispenser #(
        .AMT_W   (AMT_W),
        .CNT_W   (CNT_W),
        .INIT_N5 (I5),
        .INIT_N10(I10),
        .INIT_N25(I25)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_amount(req_amount),
        .req_ready (req_ready),
        .coin_out  (coin_out),
        .coin_valid(coin_valid),
        .coin_ack  (coin_ack),
        .done      (done),
        .fail      (fail),
        .remaining (remaining),
        .refill    (refill),
        .n5        (n5),
        .n10       (n10),
        .n25       (n25)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    int ack_mode = 0;  // 0 tied high, 1 random, 2 stall then ack, 3 never ack
    int stall_cnt = 0;

    // Reference model state: inventory, residue, planned coin queue, outcome.
    int m_phase = PhIdle;
    int m_rem = 0;
    int m_i5 = I5, m_i10 = I10, m_i25 = I25;
    int m_cur = 0;
    bit m_ok = 1'b0;
    int m_plan[$];
    int m_log[$];

    bit got_done, got_fail;

    function automatic int coin_value(input int code);
        case (code)
            1: return 5;
            2: return 10;
            3: return 25;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: at acceptance the whole coin plan is worked out greedily with plain arithmetic;
    // afterwards the timeline just walks that plan, one coin per handshake.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_phase = PhIdle;
            m_rem = 0;
            m_i5 = I5; m_i10 = I10; m_i25 = I25;
            m_cur = 0;
            m_plan.delete();
        end else begin
            case (m_phase)
                PhIdle: begin
                    if (refill) begin
                        m_i5 = I5; m_i10 = I10; m_i25 = I25;
                    end
                    if (req_valid) begin
                        int r, a5, a10, a25;
                        m_rem = int'(req_amount);
                        r = m_rem; a5 = m_i5; a10 = m_i10; a25 = m_i25;
                        m_plan.delete();
                        m_ok = 1'b0;
                        for (int k = 0; k < 64; k++) begin
                            if (r == 0) begin m_ok = 1'b1; break; end
                            if (r % 5 != 0) break;
                            if (r >= 25 && a25 > 0) begin
                                m_plan.push_back(3); r -= 25; a25--;
                            end else if (r >= 10 && a10 > 0) begin
                                m_plan.push_back(2); r -= 10; a10--;
                            end else if (a5 > 0) begin
                                m_plan.push_back(1); r -= 5; a5--;
                            end else break;
                        end
                        m_phase = PhSelect;
                    end
                end
                PhSelect: begin
                    if (m_plan.size() > 0) begin
                        m_cur = m_plan.pop_front();
                        m_phase = PhCoin;
                    end else begin
                        m_phase = PhReport;
                    end
                end
                PhCoin: begin
                    if (coin_ack) begin
                        m_rem -= coin_value(m_cur);
                        if (m_cur == 1) m_i5--;
                        else if (m_cur == 2) m_i10--;
                        else m_i25--;
                        m_log.push_back(m_cur);
                        m_phase = PhSelect;
                    end
                end
                default: m_phase = PhIdle;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("req_ready", 32'(req_ready), 32'(m_phase == PhIdle));
            check("coin_valid", 32'(coin_valid), 32'(m_phase == PhCoin));
            check("coin_out", 32'(coin_out), (m_phase == PhCoin) ? m_cur : 0);
            check("done", 32'(done), 32'(m_phase == PhReport && m_ok));
            check("fail", 32'(fail), 32'(m_phase == PhReport && !m_ok));
            check("remaining", 32'(remaining), m_rem);
            check("n5", 32'(n5), m_i5);
            check("n10", 32'(n10), m_i10);
            check("n25", 32'(n25), m_i25);
        end
    end

    // coin_ack driver.
    initial forever begin
        @(negedge clk);
        stall_cnt = coin_valid ? stall_cnt + 1 : 0;
        case (ack_mode)
            0: coin_ack = 1'b1;
            1: coin_ack = 1'($urandom_range(0, 1));
            2: coin_ack = (stall_cnt >= 5);
            default: coin_ack = 1'b0;
        endcase
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0; refill = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_req(input int amt, input bit rf);
        int w;
        w = 0;
        while (!req_ready && w < 100) begin @(negedge clk); w++; end
        if (!req_ready) check("ready_timeout", 0, 1);
        m_log.delete();
        req_valid = 1'b1; req_amount = AMT_W'(amt); refill = rf;
        @(negedge clk);
        req_valid = 1'b0; refill = 1'b0;
    endtask

    task automatic wait_result();
        int w;
        got_done = 1'b0; got_fail = 1'b0;
        for (w = 0; w < 600; w++) begin
            if (done || fail) break;
            @(negedge clk);
        end
        got_done = done; got_fail = fail;
        if (!(done || fail)) check("result_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic run_req(input int amt, input bit rf);
        send_req(amt, rf);
        wait_result();
    endtask

    task automatic expect_log(input string name, input int a0, input int a1, input int a2,
                              input int len);
        int exp[3];
        exp[0] = a0; exp[1] = a1; exp[2] = a2;
        check({name, "_len"}, m_log.size(), len);
        for (int i = 0; i < len && i < 3 && i < m_log.size(); i++)
            check({name, "_coin"}, m_log[i], exp[i]);
    endtask

    initial begin
        int amt;
        bit rf;
        do_reset();
        chk_en = 1'b1;
        check("rst_n5", 32'(n5), 8);
        check("rst_n10", 32'(n10), 8);
        check("rst_n25", 32'(n25), 4);
        check("rst_ready", 32'(req_ready), 1);
        check("rst_valid", 32'(coin_valid), 0);
        check("rst_rem", 32'(remaining), 0);

        // 40 with ack tied high: 25, 10, 5.
        ack_mode = 0;
        run_req(40, 1'b0);
        expect_log("pay40", 3, 2, 1, 3);
        check("pay40_done", 32'(got_done), 1);
        check("pay40_rem", 32'(remaining), 0);
        check("pay40_n25", 32'(n25), 3);
        check("pay40_n10", 32'(n10), 7);
        check("pay40_n5", 32'(n5), 7);

        // Non-multiple of 5 fails at once with the residue shown.
        run_req(3, 1'b0);
        check("pay3_fail", 32'(got_fail), 1);
        check("pay3_coins", m_log.size(), 0);
        check("pay3_rem", 32'(remaining), 3);
        check("pay3_n25", 32'(n25), 3);

        // Amount 0 completes with no coins.
        run_req(0, 1'b0);
        check("pay0_done", 32'(got_done), 1);

        // 55 with stalled acks: 25, 25, 5.
        do_reset();
        ack_mode = 2;
        run_req(55, 1'b0);
        expect_log("pay55", 3, 3, 1, 3);
        check("pay55_done", 32'(got_done), 1);
        check("pay55_n25", 32'(n25), 2);

        // Drain the 25s, then pay with 10s only, then exhaust everything.
        do_reset();
        ack_mode = 0;
        run_req(100, 1'b0);
        check("drain_n25", 32'(n25), 0);
        run_req(50, 1'b0);
        check("pay50_len", m_log.size(), 5);
        check("pay50_n10", 32'(n10), 3);
        run_req(30, 1'b0);
        run_req(40, 1'b0);
        check("empty_n10", 32'(n10), 0);
        check("empty_n5", 32'(n5), 0);
        run_req(5, 1'b0);
        check("pay5_fail", 32'(got_fail), 1);
        check("pay5_rem", 32'(remaining), 5);

        // Greedy limit: n25=1, n10=3, n5=0 then 30 pays 25 and fails with 5 left.
        do_reset();
        run_req(75, 1'b0);
        run_req(20, 1'b0);
        run_req(20, 1'b0);
        run_req(10, 1'b0);
        for (int i = 0; i < 8; i++) run_req(5, 1'b0);
        check("greedy_n25", 32'(n25), 1);
        check("greedy_n10", 32'(n10), 3);
        check("greedy_n5", 32'(n5), 0);
        run_req(30, 1'b0);
        expect_log("greedy30", 3, 0, 0, 1);
        check("greedy30_fail", 32'(got_fail), 1);
        check("greedy30_rem", 32'(remaining), 5);

        // Refill ignored mid-dispense; reset discards the pending coin and reloads inventory.
        do_reset();
        run_req(25, 1'b0);
        ack_mode = 3;
        send_req(25, 1'b0);
        for (int w = 0; w < 10 && !coin_valid; w++) @(negedge clk);
        check("hold_valid", 32'(coin_valid), 1);
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        @(negedge clk);
        check("refill_ignored_n25", 32'(n25), 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", 32'(coin_valid), 0);
        check("abort_ready", 32'(req_ready), 1);
        check("abort_n25", 32'(n25), 4);

        // Randomized traffic with random acks and refills, checked cycle by cycle.
        ack_mode = 1;
        for (int t = 0; t < 80; t++) begin
            amt = int'($urandom_range(0, 127));
            rf = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) begin
                refill = 1'b1;
                @(negedge clk);
                refill = 1'b0;
            end
            run_req(amt, rf);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
